// File: rtl/io_confirm_sequencer.sv
// io_confirm_sequencer
// Holds a CPU switch read in a stall until the operator presses a debounced
// confirm button. On that press the switches are latched and returned with a
// one-cycle valid pulse, so software reads a deliberately entered value.
// DEBOUNCE_CYCLES must be at least 2.

module io_confirm_sequencer #(
    parameter int SW_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                io_rd_req,
    input  logic                btn_raw,
    input  logic [SW_WIDTH-1:0] switch_in,
    output logic                stall,
    output logic                rd_valid,
    output logic [SW_WIDTH-1:0] rd_data,
    output logic                wait_led
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t            state;
    logic              btn_meta;
    logic              btn_sync;
    logic              btn_stable;
    logic              btn_prev;
    logic [CNT_W-1:0]  cnt;
    logic              press;

    // Two-flop synchroniser bringing the asynchronous button into the clock domain
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Debouncer: the synchronised level must disagree for DEBOUNCE_CYCLES in a row
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            btn_stable <= 1'b0;
        end else if (btn_sync == btn_stable) begin
            cnt <= '0;
        end else if (cnt == CNT_MAX) begin
            cnt        <= '0;
            btn_stable <= btn_sync;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level so only a rising edge counts as a press
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_prev <= 1'b0;
        end else begin
            btn_prev <= btn_stable;
        end
    end

    assign press = btn_stable & ~btn_prev;

    // Transaction FSM with registered valid/LED outputs and the capture register
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            rd_valid <= 1'b0;
            wait_led <= 1'b0;
            rd_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    rd_valid <= 1'b0;
                    if (io_rd_req) begin
                        state    <= ST_WAIT;
                        wait_led <= 1'b1;
                    end else begin
                        wait_led <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (!io_rd_req) begin
                        state    <= ST_IDLE;
                        wait_led <= 1'b0;
                        rd_valid <= 1'b0;
                    end else if (press) begin
                        state    <= ST_DONE;
                        rd_data  <= switch_in;
                        wait_led <= 1'b0;
                        rd_valid <= 1'b1;
                    end else begin
                        wait_led <= 1'b1;
                        rd_valid <= 1'b0;
                    end
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    rd_valid <= 1'b0;
                    wait_led <= 1'b0;
                end
                default: begin
                    state    <= ST_IDLE;
                    rd_valid <= 1'b0;
                    wait_led <= 1'b0;
                end
            endcase
        end
    end

    // rd_valid is high exactly while the FSM sits in DONE, so it doubles as the DONE flag
    assign stall = io_rd_req & ~rd_valid;

endmodule

// File: tb/tb_io_confirm_sequencer.sv
// Directed bench for io_confirm_sequencer with DEBOUNCE_CYCLES=4, SW_WIDTH=8.

module tb_io_confirm_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       io_rd_req;
    logic       btn_raw;
    logic [7:0] switch_in;
    logic       stall;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       wait_led;

    int compared   = 0;
    int mismatched = 0;

    io_confirm_sequencer #(
        .SW_WIDTH       (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .io_rd_req(io_rd_req),
        .btn_raw  (btn_raw),
        .switch_in(switch_in),
        .stall    (stall),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .wait_led (wait_led)
    );

    // Free-running 10 ns clock
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic apply_stimulus(input logic req, input logic btn, input logic [7:0] sw);
        io_rd_req = req;
        btn_raw   = btn;
        switch_in = sw;
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Safety net so a stuck run still ends
    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed scenario sequence
    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 1'b0, 8'h00);
        tick(2);
        check_output("reset_rd_valid", rd_valid, 0);
        check_output("reset_wait_led", wait_led, 0);
        check_output("reset_rd_data", rd_data, 8'h00);
        check_output("reset_stall_low", stall, 0);
        check_output("reset_cnt", dut.cnt, 0);
        check_output("reset_btn_stable", dut.btn_stable, 0);
        apply_stimulus(1'b1, 1'b0, 8'h00);
        check_output("reset_stall_follows_req", stall, 1);
        apply_stimulus(1'b0, 1'b0, 8'h00);
        rst = 1'b0;
        tick(1);

        // Basic read
        $display("[TB] basic read");
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        check_output("basic_stall_zero_latency", stall, 1);
        check_output("basic_idle_led", wait_led, 0);
        tick(1);
        check_output("basic_wait_led", wait_led, 1);
        tick(8);
        check_output("basic_still_waiting", wait_led, 1);
        check_output("basic_no_valid_yet", rd_valid, 0);
        apply_stimulus(1'b1, 1'b1, 8'hA5);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check_output($sformatf("basic_valid_k%0d", k), rd_valid, (k == 7) ? 1 : 0);
            check_output($sformatf("basic_stall_k%0d", k), stall, (k == 7) ? 0 : 1);
        end
        check_output("basic_rd_data", rd_data, 8'hA5);
        check_output("basic_led_done", wait_led, 0);
        apply_stimulus(1'b0, 1'b1, 8'hA5);
        tick(1);
        check_output("basic_valid_one_cycle", rd_valid, 0);
        check_output("basic_data_held", rd_data, 8'hA5);
        tick(12);
        apply_stimulus(1'b0, 1'b0, 8'hA5);
        tick(8);
        check_output("basic_release_stable", dut.btn_stable, 0);

        // Bounce rejection
        $display("[TB] bounce rejection");
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        tick(1);
        check_output("bounce_wait_led", wait_led, 1);
        apply_stimulus(1'b1, 1'b1, 8'hA5);
        tick(1);
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        tick(1);
        apply_stimulus(1'b1, 1'b1, 8'hA5);
        tick(1);
        apply_stimulus(1'b1, 1'b0, 8'hA5);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_output($sformatf("bounce_valid_%0d", k), rd_valid, 0);
            check_output($sformatf("bounce_stable_%0d", k), dut.btn_stable, 0);
        end
        check_output("bounce_still_wait", wait_led, 1);

        // Withdrawn request
        $display("[TB] withdrawn request");
        apply_stimulus(1'b0, 1'b0, 8'h3C);
        check_output("withdraw_stall_drops", stall, 0);
        tick(1);
        check_output("withdraw_idle_led", wait_led, 0);
        check_output("withdraw_no_valid", rd_valid, 0);
        apply_stimulus(1'b0, 1'b1, 8'h3C);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_output($sformatf("withdraw_valid_%0d", k), rd_valid, 0);
        end
        check_output("withdraw_data_kept", rd_data, 8'hA5);
        apply_stimulus(1'b0, 1'b0, 8'h3C);
        tick(8);

        // Held button before request
        $display("[TB] held button");
        apply_stimulus(1'b0, 1'b1, 8'h11);
        tick(20);
        check_output("held_stable_high", dut.btn_stable, 1);
        apply_stimulus(1'b1, 1'b1, 8'h11);
        tick(1);
        check_output("held_wait_led", wait_led, 1);
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check_output($sformatf("held_no_capture_%0d", k), rd_valid, 0);
        end
        apply_stimulus(1'b1, 1'b0, 8'h11);
        tick(8);
        check_output("held_release_stable", dut.btn_stable, 0);
        check_output("held_release_no_valid", rd_valid, 0);
        check_output("held_release_wait", wait_led, 1);
        apply_stimulus(1'b1, 1'b1, 8'h77);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check_output($sformatf("held_repress_valid_k%0d", k), rd_valid, (k == 7) ? 1 : 0);
        end
        check_output("held_repress_data", rd_data, 8'h77);
        apply_stimulus(1'b0, 1'b1, 8'h77);
        tick(1);
        apply_stimulus(1'b0, 1'b0, 8'h77);
        tick(8);

        // Reset mid-WAIT with the button bouncing
        $display("[TB] reset mid-wait");
        apply_stimulus(1'b1, 1'b0, 8'h55);
        tick(1);
        check_output("rstwait_wait_led", wait_led, 1);
        apply_stimulus(1'b1, 1'b1, 8'h55);
        tick(3);
        check_output("rstwait_cnt_running", dut.cnt, 1);
        rst = 1'b1;
        apply_stimulus(1'b1, 1'b0, 8'h55);
        tick(1);
        check_output("rstwait_idle_led", wait_led, 0);
        check_output("rstwait_no_valid", rd_valid, 0);
        check_output("rstwait_rd_data", rd_data, 8'h00);
        check_output("rstwait_cnt", dut.cnt, 0);
        rst = 1'b0;
        apply_stimulus(1'b0, 1'b0, 8'h55);
        tick(8);

        // Back-to-back transactions
        $display("[TB] back-to-back");
        apply_stimulus(1'b1, 1'b0, 8'h01);
        tick(1);
        check_output("b2b_first_wait", wait_led, 1);
        apply_stimulus(1'b1, 1'b1, 8'h01);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check_output($sformatf("b2b_first_valid_k%0d", k), rd_valid, (k == 7) ? 1 : 0);
        end
        check_output("b2b_first_data", rd_data, 8'h01);
        check_output("b2b_first_stall_done", stall, 0);
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        tick(1);
        check_output("b2b_stall_after_done", stall, 1);
        check_output("b2b_valid_dropped", rd_valid, 0);
        check_output("b2b_idle_led", wait_led, 0);
        tick(1);
        check_output("b2b_second_wait", wait_led, 1);
        apply_stimulus(1'b1, 1'b0, 8'hFF);
        tick(8);
        check_output("b2b_release_no_valid", rd_valid, 0);
        apply_stimulus(1'b1, 1'b1, 8'hFF);
        for (int k = 1; k <= 7; k++) begin
            tick(1);
            check_output($sformatf("b2b_second_valid_k%0d", k), rd_valid, (k == 7) ? 1 : 0);
        end
        check_output("b2b_second_data", rd_data, 8'hFF);
        apply_stimulus(1'b0, 1'b1, 8'h00);
        tick(1);
        check_output("b2b_end_no_valid", rd_valid, 0);
        check_output("b2b_end_data_held", rd_data, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/io_confirm_sequencer.md
# io_confirm_sequencer

Sequences CPU reads of the switch bank behind a debounced confirm button, so software reads a deliberately entered value rather than whatever the switches show mid-edit. It sits between the memory/IO decode logic and the switch/button pins. When the decoder flags a switch read, the block stalls the CPU until the operator presses confirm, then latches the switches and returns them with a one-cycle valid pulse.

## Interface
Parameters:
- `SW_WIDTH`, 8: switch bank width.
- `DEBOUNCE_CYCLES`, 20: cycles `btn_sync` must differ from `btn_stable` before `btn_stable` flips. Must be ≥2. The board build overrides it to about 1 ms of clocks.

Ports:
- `clk`, in, 1: single system clock; every register in the block uses its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `io_rd_req`, in, 1: decoder asserts for a switch-address ioRead; held high until `rd_valid`.
- `btn_raw`, in, 1: raw confirm button, asynchronous, bouncy, active-high.
- `switch_in`, in, `SW_WIDTH`: raw switch levels.
- `stall`, out, 1: freeze CPU PC/pipeline while high. Combinational.
- `rd_valid`, out, 1: one-cycle pulse; `rd_data` is valid for the CPU to write back.
- `rd_data`, out, `SW_WIDTH`: switch value latched on the confirm press.
- `wait_led`, out, 1: high while waiting for the operator; drives a "press confirm" LED.

## Operation
- Synchroniser: two-flop chain `btn_raw` → `btn_meta` → `btn_sync`.
- Debouncer: counter `cnt` of width clog2(`DEBOUNCE_CYCLES`).
  - If `btn_sync == btn_stable`: `cnt` ← 0.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: `btn_stable` ← `btn_sync` and `cnt` ← 0.
  - Else: `cnt` ← `cnt`+1.
  - A bounce shorter than `DEBOUNCE_CYCLES` restarts the count and is never seen.
- Press detect: `press` = `btn_stable & ~btn_prev`, where `btn_prev` is `btn_stable` delayed one cycle. Only a rising edge counts; a held button never re-triggers.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: if `io_rd_req` is high, go to WAIT. Otherwise stay.
  - WAIT, with `io_rd_req` low (request withdrawn): go to IDLE. No `rd_valid`; `rd_data` is unchanged.
  - WAIT, with `press`: `rd_data` ← `switch_in` and go to DONE.
  - WAIT, otherwise: stay.
  - DONE: go to IDLE unconditionally.
- Outputs:
  - `stall` = `io_rd_req & (state != DONE)`.
  - `rd_valid` = (state == DONE).
  - `wait_led` = (state == WAIT).
- Button already held when WAIT is entered: no `press` occurs. The operator must release the button (debounced) and press again.
- `press` while in IDLE or DONE is ignored and not queued.
- `io_rd_req` high in the cycle after DONE starts a new transaction. That cycle is IDLE, so `stall` is high.

## Timing
- Reset values:
  - State: IDLE.
  - `btn_meta`, `btn_sync`, `btn_stable`, `btn_prev`: 0.
  - `cnt`: 0.
  - `rd_data`: 0.
  - Outputs: `stall` follows `io_rd_req`; `rd_valid` = 0; `wait_led` = 0.
- `stall` rises in the same cycle `io_rd_req` rises, with zero latency.
- Raw press latency: `btn_raw` rises and stays high before edge E0.
  - `btn_sync` is high after edge E1.
  - `btn_stable` is high after edge E(1+`DEBOUNCE_CYCLES`).
  - `press` is high during that cycle.
  - `rd_data` is captured at the next edge, when the FSM enters DONE.
  - `rd_valid` is high, and `stall` low, for the one cycle after that edge.
- Release latency matches press latency and produces no event.
- Minimum read latency (button rises exactly as the request starts) is `DEBOUNCE_CYCLES`+3 cycles of stall.
- `rd_data` holds its value until the next successful capture, including after `rd_valid` drops.
- Reset mid-WAIT or mid-DONE:
  - The FSM returns to IDLE and the debouncer clears.
  - `rd_valid` = 0 at the first post-reset cycle.
  - A button held through reset reads as a fresh press once debounced. This is acceptable because the FSM is IDLE.
- `switch_in` is sampled only on the capture edge and is not synchronised. Switches are quasi-static.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4 and `SW_WIDTH`=8.
- Basic read:
  - Stimulus: `io_rd_req`=1 and `switch_in`=0xA5; clean `btn_raw` press 10 cycles later, held 20 cycles.
  - Required: `stall` high from the request cycle; `wait_led` high while waiting; `rd_data`=0xA5 with a single `rd_valid` pulse exactly 1+4+2 cycles after `btn_raw` rises; `stall` low during that pulse.
- Bounce rejection:
  - Stimulus: in WAIT, `btn_raw` toggles 1,0,1,0 at 1-cycle intervals, then stays 0.
  - Required: no `press`; `rd_valid` stays 0; `btn_stable` stays 0.
- Held button:
  - Stimulus: `btn_raw` held high 20 cycles before `io_rd_req` rises.
  - Required: no capture. After the button is released (debounced) and pressed again, the capture happens with the value present at the second press.
- Withdrawn request:
  - Stimulus: enter WAIT, then drop `io_rd_req`, then press confirm.
  - Required: return to IDLE; `rd_valid`=0; `rd_data` keeps its old value.
- Reset mid-WAIT:
  - Stimulus: assert `rst` for 1 cycle during WAIT with the button bouncing.
  - Required: IDLE; `rd_valid`=0; `rd_data`=0; `cnt`=0.
- Back-to-back:
  - Stimulus: two requests with `switch_in` 0x01, then 0xFF, and two separate presses.
  - Required: two `rd_valid` pulses carrying 0x01 and 0xFF; `stall` is high again in the cycle immediately after the first DONE.
